branch_predictor: RTL and testbench

Dynamic branch predictor for the RV32I core. It forms the producer side of the branch-decision path: it predicts direction and target at fetch, and the resolved outcome from the branch comparator trains it. The block holds a direct-mapped table of 2-bit saturating counters with a tagged target buffer. An initialisation sweep state machine clears the table after reset.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tagged target buffer and post-reset clearing sweep.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {INIT, RUN} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               ptr_q;
  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][1:0]        ctr_q;
  logic [ENTRIES-1:0][31:0]       tgt_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
  end

  assign ready = (state_q == RUN);

  // Lookup reads registered state only; same-cycle updates are not bypassed.
  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign pred_hit    = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit & ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign accept = upd_valid & ready;

  // Single write port: the sweep owns it in INIT, the update path in RUN.
  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) begin
      valid_q[ptr_q] <= 1'b0;
      ctr_q[ptr_q]   <= 2'b01;
    end else if (!rst && accept) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          tgt_q[up_idx] <= upd_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_q, mp_q;
  logic        unused_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (accept) begin
      if (br_q != 32'hFFFF_FFFF) br_q <= br_q + 32'd1;
      if (upd_mispredict && mp_q != 32'hFFFF_FFFF) mp_q <= mp_q + 32'd1;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
  assign unused_pc        = ^{lookup_pc, upd_pc};
`else
  logic unused_pc;

  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
  assign unused_pc        = ^{lookup_pc, upd_pc, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, TAG_W=8).
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken, ready;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] stat_branches, stat_mispredicts;

  int vecs = 0;
  int errs = 0;

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ready(ready), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispredict = 1'b0; lookup_pc = 32'h100;
    tick(); tick();
    vecs += 6;
    if (ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b want 0", ready); end
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL rst_hit got %b want 0", pred_hit); end
    if (pred_taken !== 1'b0) begin errs++; $display("FAIL rst_taken got %b want 0", pred_taken); end
    if (pred_target !== 32'h104) begin errs++; $display("FAIL rst_target got %h want 104", pred_target); end
    if (stat_branches !== 32'd0) begin errs++; $display("FAIL rst_stat_br got %0d want 0", stat_branches); end
    if (stat_mispredicts !== 32'd0) begin errs++; $display("FAIL rst_stat_mp got %0d want 0", stat_mispredicts); end
    rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      vecs++;
      if (ready !== 1'b0) begin errs++; $display("FAIL sweep_ready cycle %0d got %b want 0", c, ready); end
      tick();
    end
    vecs += 3;
    if (ready !== 1'b1) begin errs++; $display("FAIL sweep_done got %b want 1", ready); end
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL post_sweep_hit got %b want 0", pred_hit); end
    if (pred_target !== 32'h104) begin errs++; $display("FAIL post_sweep_target got %h want 104", pred_target); end
  endtask

  task automatic test_alloc_hit();
    upd(32'h200, 1'b1, 32'h80, 1'b0);
    lookup_pc = 32'h200; #1;
    vecs += 3;
    if (pred_hit !== 1'b1) begin errs++; $display("FAIL alloc_hit got %b want 1", pred_hit); end
    if (pred_taken !== 1'b1) begin errs++; $display("FAIL alloc_taken got %b want 1", pred_taken); end
    if (pred_target !== 32'h80) begin errs++; $display("FAIL alloc_target got %h want 80", pred_target); end
  endtask

  task automatic test_saturation();
    repeat (3) upd(32'h200, 1'b1, 32'h80, 1'b0);      // ctr 3
    repeat (2) upd(32'h200, 1'b0, 32'h0, 1'b0);       // ctr 1
    lookup_pc = 32'h200; #1;
    vecs += 3;
    if (pred_hit !== 1'b1) begin errs++; $display("FAIL sat_hi_hit got %b want 1", pred_hit); end
    if (pred_taken !== 1'b0) begin errs++; $display("FAIL sat_hi_taken got %b want 0", pred_taken); end
    if (pred_target !== 32'h204) begin errs++; $display("FAIL sat_hi_target got %h want 204", pred_target); end
    repeat (3) upd(32'h200, 1'b0, 32'h0, 1'b0);       // ctr 0
    upd(32'h200, 1'b1, 32'h90, 1'b0);                 // ctr 1
    vecs += 2;
    if (pred_taken !== 1'b0) begin errs++; $display("FAIL sat_lo_taken got %b want 0", pred_taken); end
    if (pred_target !== 32'h204) begin errs++; $display("FAIL sat_lo_target got %h want 204", pred_target); end
    upd(32'h200, 1'b1, 32'h90, 1'b0);                 // ctr 2
    vecs += 2;
    if (pred_taken !== 1'b1) begin errs++; $display("FAIL retrain_taken got %b want 1", pred_taken); end
    if (pred_target !== 32'h90) begin errs++; $display("FAIL retrain_target got %h want 90", pred_target); end
  endtask

  task automatic test_alias();
    upd(32'h200, 1'b1, 32'h80, 1'b0);                 // ctr 3, target 0x80
    lookup_pc = 32'h300; #1;
    vecs += 3;
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL alias_hit got %b want 0", pred_hit); end
    if (pred_taken !== 1'b0) begin errs++; $display("FAIL alias_taken got %b want 0", pred_taken); end
    if (pred_target !== 32'h304) begin errs++; $display("FAIL alias_target got %h want 304", pred_target); end
    upd(32'h300, 1'b0, 32'h0, 1'b0);
    lookup_pc = 32'h200; #1;
    vecs += 3;
    if (pred_hit !== 1'b1) begin errs++; $display("FAIL alias_keep_hit got %b want 1", pred_hit); end
    if (pred_taken !== 1'b1) begin errs++; $display("FAIL alias_keep_taken got %b want 1", pred_taken); end
    if (pred_target !== 32'h80) begin errs++; $display("FAIL alias_keep_target got %h want 80", pred_target); end
  endtask

  task automatic test_same_cycle();
    lookup_pc = 32'h300;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h400; upd_mispredict = 1'b0;
    #1;
    vecs += 2;
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL same_cyc_hit got %b want 0", pred_hit); end
    if (pred_target !== 32'h304) begin errs++; $display("FAIL same_cyc_target got %h want 304", pred_target); end
    tick();
    upd_valid = 1'b0; #1;
    vecs += 3;
    if (pred_hit !== 1'b1) begin errs++; $display("FAIL next_cyc_hit got %b want 1", pred_hit); end
    if (pred_taken !== 1'b1) begin errs++; $display("FAIL next_cyc_taken got %b want 1", pred_taken); end
    if (pred_target !== 32'h400) begin errs++; $display("FAIL next_cyc_target got %h want 400", pred_target); end
    lookup_pc = 32'h302; #1;
    vecs++;
    if (pred_target !== 32'h400) begin errs++; $display("FAIL low_bits_target got %h want 400", pred_target); end
    lookup_pc = 32'h200; #1;
    vecs++;
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL evicted_hit got %b want 0", pred_hit); end
    lookup_pc = 32'hFFFF_FFFC; #1;
    vecs++;
    if (pred_target !== 32'h0) begin errs++; $display("FAIL wrap_target got %h want 0", pred_target); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp_br, exp_mp;
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (30) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      upd_valid = (c == 10); upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h40; upd_mispredict = 1'b1;
      vecs++;
      if (ready !== 1'b0) begin errs++; $display("FAIL resweep_ready cycle %0d got %b want 0", c, ready); end
      tick();
    end
    upd_valid = 1'b0;
    lookup_pc = 32'h500; #1;
    vecs += 4;
    if (ready !== 1'b1) begin errs++; $display("FAIL resweep_done got %b want 1", ready); end
    if (pred_hit !== 1'b0) begin errs++; $display("FAIL init_upd_dropped got %b want 0", pred_hit); end
    if (stat_branches !== 32'd0) begin errs++; $display("FAIL init_stat_br got %0d want 0", stat_branches); end
    if (stat_mispredicts !== 32'd0) begin errs++; $display("FAIL init_stat_mp got %0d want 0", stat_mispredicts); end
    upd(32'h600, 1'b1, 32'h10, 1'b1);
    upd(32'h604, 1'b0, 32'h0, 1'b0);
    upd(32'h600, 1'b1, 32'h10, 1'b0);
    upd(32'h608, 1'b0, 32'h0, 1'b1);
    upd(32'h600, 1'b0, 32'h0, 1'b0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    exp_br = 32'd5; exp_mp = 32'd2;
`else
    exp_br = 32'd0; exp_mp = 32'd0;
`endif
    vecs += 2;
    if (stat_branches !== exp_br) begin errs++; $display("FAIL stat_br got %0d want %0d", stat_branches, exp_br); end
    if (stat_mispredicts !== exp_mp) begin errs++; $display("FAIL stat_mp got %0d want %0d", stat_mispredicts, exp_mp); end
    rst = 1'b1; tick();
    vecs += 3;
    if (stat_branches !== 32'd0) begin errs++; $display("FAIL stat_br_clr got %0d want 0", stat_branches); end
    if (stat_mispredicts !== 32'd0) begin errs++; $display("FAIL stat_mp_clr got %0d want 0", stat_mispredicts); end
    if (ready !== 1'b0) begin errs++; $display("FAIL run_rst_ready got %b want 0", ready); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alloc_hit();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
